// File: rtl/fib_index_finder.sv
// Iterative inverse Fibonacci search: finds the smallest n with F(n) >= value.
// Optional result-term output enabled by defining FIB_VALUE_OUT_EN.
module fib_index_finder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] index,
    output logic             is_fib,
    output logic             overflow
`ifdef FIB_VALUE_OUT_EN
    ,
    output logic [WIDTH-1:0] fib_value
`endif
);

    typedef enum logic {StIdle, StSearch} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] index_q, index_d;
    logic             is_fib_q, is_fib_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
`ifdef FIB_VALUE_OUT_EN
    logic [WIDTH-1:0] fib_value_q, fib_value_d;
`endif

    logic found;
    assign found = (a_q >= {1'b0, xr_q});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            n_q         <= '0;
            xr_q        <= '0;
            index_q     <= '0;
            is_fib_q    <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef FIB_VALUE_OUT_EN
            fib_value_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            n_q         <= n_d;
            xr_q        <= xr_d;
            index_q     <= index_d;
            is_fib_q    <= is_fib_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
`ifdef FIB_VALUE_OUT_EN
            fib_value_q <= fib_value_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        n_d         = n_q;
        xr_d        = xr_q;
        index_d     = index_q;
        is_fib_d    = is_fib_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
`ifdef FIB_VALUE_OUT_EN
        fib_value_d = fib_value_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    xr_d    = value;
                    a_d     = '0;
                    b_d     = {{WIDTH{1'b0}}, 1'b1};
                    n_d     = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (found) begin
                    index_d     = n_q;
                    is_fib_d    = (a_q == {1'b0, xr_q});
                    overflow_d  = a_q[WIDTH];
                    done_d      = 1'b1;
`ifdef FIB_VALUE_OUT_EN
                    fib_value_d = a_q[WIDTH] ? '0 : a_q[WIDTH-1:0];
`endif
                    state_d     = StIdle;
                end else begin
                    // b may wrap here, but only after a has crossed the range and ended the search
                    a_d = b_q;
                    b_d = a_q + b_q;
                    n_d = n_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q == StSearch);
    assign done     = done_q;
    assign index    = index_q;
    assign is_fib   = is_fib_q;
    assign overflow = overflow_q;
`ifdef FIB_VALUE_OUT_EN
    assign fib_value = fib_value_q;
`endif

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder (WIDTH=8) with a queue-based result scoreboard.
module tb_fib_index_finder;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] index;
    logic             is_fib;
    logic             overflow;
`ifdef FIB_VALUE_OUT_EN
    logic [WIDTH-1:0] fib_value;
`endif

    fib_index_finder #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .index    (index),
        .is_fib   (is_fib),
        .overflow (overflow)
`ifdef FIB_VALUE_OUT_EN
        ,
        .fib_value(fib_value)
`endif
    );

    always #5 clock = ~clock;

    longint cycle_cnt = 0;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        longint idx;
        bit     fib;
        bit     ovf;
        longint fv;
        longint launch;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model works in 64-bit so the range limit is an explicit compare.
    function automatic exp_t model(input longint x);
        exp_t   e;
        longint a = 0, b = 1, t;
        longint n = 0;
        while (a < x) begin
            t = a + b;
            a = b;
            b = t;
            n++;
        end
        e.ovf    = (a > longint'((1 << WIDTH) - 1));
        e.fib    = (a == x) && !e.ovf;
        e.idx    = n;
        e.fv     = e.ovf ? 0 : a;
        e.launch = cycle_cnt;
        return e;
    endfunction

    // Call at a negedge; drives start for the next rising edge.
    task automatic launch(input logic [WIDTH-1:0] x);
        value = x;
        start = 1'b1;
        sb.push_back(model(longint'(x)));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        e = sb.pop_front();
        if (done !== 1'b1) begin
            check({tag, " timeout"}, longint'(done), 1);
            return;
        end
        check({tag, " latency"}, cycle_cnt - e.launch - 1, e.idx + 1);
        check({tag, " index"}, longint'(index), e.idx);
        check({tag, " is_fib"}, longint'(is_fib), longint'(e.fib));
        check({tag, " overflow"}, longint'(overflow), longint'(e.ovf));
`ifdef FIB_VALUE_OUT_EN
        check({tag, " fib_value"}, longint'(fib_value), e.fv);
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clock);
        check("rst busy", longint'(busy), 0);
        check("rst done", longint'(done), 0);
        check("rst index", longint'(index), 0);
        check("rst is_fib", longint'(is_fib), 0);
        check("rst overflow", longint'(overflow), 0);
        reset = 1'b0;
        @(negedge clock);

        launch(8'd0);
        wait_result("x0");
        @(negedge clock);
        check("x0 done pulse", longint'(done), 0);
        check("x0 index hold", longint'(index), 0);

        launch(8'd1);
        wait_result("x1");
        launch(8'd5);
        check("x5 busy", longint'(busy), 1);
        wait_result("x5");
        launch(8'd6);
        wait_result("x6");
        launch(8'd233);
        wait_result("x233");
        launch(8'd234);
        wait_result("x234");
        launch(8'd255);
        wait_result("x255");

        // start during a search must not disturb the captured target
        launch(8'd100);
        repeat (2) @(negedge clock);
        value = 8'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        value = 8'd77;
        wait_result("x100 ignore");
        // back-to-back: start presented in the done cycle
        launch(8'd2);
        wait_result("x2 b2b");

        launch(8'd200);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid rst busy", longint'(busy), 0);
        check("mid rst done", longint'(done), 0);
        check("mid rst index", longint'(index), 0);
        check("mid rst is_fib", longint'(is_fib), 0);
        check("mid rst overflow", longint'(overflow), 0);
        void'(sb.pop_front());
        reset = 1'b0;
        @(negedge clock);
        launch(8'd8);
        wait_result("x8");

        for (int i = 0; i < 4; i++) begin
            launch(8'($urandom_range(0, 255)));
            wait_result("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
